// File: rtl/fifo_rd_ptr_empty.sv
// Read-side pointer and empty/level controller for the async FIFO.
// Runs only in rd_clk; consumes the synchronized Gray write pointer.
module fifo_rd_ptr_empty #(
  parameter int ADDR_WIDTH      = 6,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   rd_sync_wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  rd_empty,
  output logic                  rd_almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  rd_underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW:0] TH = PW'(ALMOST_EMPTY_TH);

  logic [PW-1:0] rd_bin;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] wr_bin;
  logic [PW-1:0] level_next;
  logic          rd_inc;

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always_comb begin
    rd_inc       = rd_en & ~rd_empty;
    rd_bin_next  = rd_bin + {{(PW-1){1'b0}}, rd_inc};
    rd_gray_next = (rd_bin_next >> 1) ^ rd_bin_next;
    wr_bin       = g2b(rd_sync_wr_ptr);
    level_next   = wr_bin - rd_bin_next;
  end

  assign rd_addr = rd_bin[ADDR_WIDTH-1:0];

  // Empty compares full-width Gray values so the wrap bit disambiguates full.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      rd_bin          <= '0;
      rd_ptr          <= '0;
      rd_empty        <= 1'b1;
      rd_almost_empty <= 1'b1;
      rd_count        <= '0;
      rd_underflow    <= 1'b0;
    end else begin
      rd_bin          <= rd_bin_next;
      rd_ptr          <= rd_gray_next;
      rd_empty        <= (rd_gray_next == rd_sync_wr_ptr);
      rd_almost_empty <= ({1'b0, level_next} <= TH);
      rd_count        <= level_next;
      if (rd_en & rd_empty)
        rd_underflow  <= 1'b1;
    end
  end

endmodule
